// File: rtl/mu_multi_out_buf.sv
// mu_multi_out_buf: NUM_CH independent packet FIFOs merged onto one output
// stream. A round-robin arbiter chooses among the non-empty channels. The
// chosen packet goes into a single registered output slot that uses a
// valid/ready handshake.
module mu_multi_out_buf #(
  parameter int DATA_W    = 256,
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int AF_THRESH = DEPTH - 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = CH_W + 1;

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] rd_word [NUM_CH];

  logic              slot_free;
  logic              grant_valid;
  logic [CH_W-1:0]   grant;
  logic [IDX_W-1:0]  idx;
  logic [CH_W-1:0]   rr_ptr_reg;
  logic [CH_W-1:0]   rr_ptr_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CH_W-1:0]   out_ch_reg;

  // The slot can take a new packet when it is empty or is being consumed now.
  assign slot_free = !out_valid_reg || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              ovf_reg;
      logic              wr_acc;

      // All flags come from the registered count only. Same-cycle pops give no relief.
      assign full[gi]        = (count_reg == CNT_W'(DEPTH));
      assign almost_full[gi] = (count_reg >= CNT_W'(AF_THRESH));
      assign empty[gi]       = (count_reg == '0);
      assign overflow[gi]    = ovf_reg;
      assign wr_acc          = wr_en[gi] && !full[gi];
      assign pop[gi]         = slot_free && grant_valid && (grant == CH_W'(gi));
      assign rd_word[gi]     = mem[rd_ptr_reg];

      // Packet storage. Storage is not cleared on reset: the pointer reset discards its contents.
      always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
          mem[wr_ptr_reg] <= wr_data[gi*DATA_W +: DATA_W];
        end
      end

      // Pointer, occupancy and sticky-overflow bookkeeping for this channel.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({wr_acc, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
          // A write into a full FIFO is dropped even when the same edge pops this channel.
          if (wr_en[gi] && full[gi]) ovf_reg <= 1'b1;
        end
      end
    end
  endgenerate

  // Round-robin search from rr_ptr upward. The loop runs backwards, so the closest non-empty channel is assigned last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
      if (idx >= IDX_W'(NUM_CH)) idx = idx - IDX_W'(NUM_CH);
      if (!empty[idx[CH_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[CH_W-1:0];
      end
    end
    rr_ptr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
  end

  // Output slot: load the granted packet when the slot is free, and hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (slot_free) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= rd_word[grant];
        out_ch_reg    <= grant;
        rr_ptr_reg    <= rr_ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mu_multi_out_buf.sv
// Self-checking bench for mu_multi_out_buf with its default parameters.
// Each accepted write pushes its packet onto a per-channel scoreboard queue.
// The monitor pops that queue on every output handshake.
module tb_mu_multi_out_buf;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct {
    logic [NUM_CH-1:0] wr_en;
    bit                keep;
    logic [NUM_CH-1:0] exp_af;
    logic [NUM_CH-1:0] exp_full;
    logic [NUM_CH-1:0] exp_ovf;
  } vec_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        wr_en;
  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0]        almost_full;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        overflow;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               out_ch;

  int    checks = 0;
  int    errors = 0;
  word_t sb [NUM_CH][$];
  word_t mon_exp;
  vec_t  tbl [17];
  word_t pkt_a, pkt_b;

  mu_multi_out_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .almost_full(almost_full), .full(full), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mk(input int ch, input int n);
    word_t w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    w[15:0] = 16'(ch * 256 + n);
    return w;
  endfunction

  task automatic set_wr(input int ch, input word_t d, input bit keep);
    wr_en[ch[1:0]] = 1'b1;
    wr_data[ch*DATA_W +: DATA_W] = d;
    if (keep) sb[ch[1:0]].push_back(d);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wr_en = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) sb[c[1:0]].delete();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_done", out_valid, 0);
  endtask

  // On each output handshake, compare the packet with the front of its channel's queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb[out_ch].size() == 0) begin
        errors++;
        $display("FAIL unexpected_pkt ch=%0d actual=%0h required=none", out_ch, out_data);
      end else begin
        mon_exp = sb[out_ch].pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL xfer_data ch=%0d actual=%0h required=%0h", out_ch, out_data, mon_exp);
        end else begin
          $display("xfer ch=%0d data=%0h", out_ch, out_data);
        end
      end
    end
  end

  initial begin
    // Table for the ch2 fill: one write per row, with the expected flags after that edge.
    for (int i = 0; i < 17; i++) begin
      tbl[i].wr_en    = 4'b0100;
      tbl[i].keep     = (i < 16);
      tbl[i].exp_af   = (i + 1 >= 12) ? 4'b0100 : 4'b0000;
      tbl[i].exp_full = (i + 1 >= 16) ? 4'b0100 : 4'b0000;
      tbl[i].exp_ovf  = (i + 1 >= 17) ? 4'b0100 : 4'b0000;
    end

    wr_data = '0;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_data", out_data, 0);

    // A single write takes two edges to reach the output and is shown for one cycle.
    out_ready = 1'b1;
    set_wr(0, word_t'(1), 1);
    tick();
    wr_en = '0;
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 1);
    chk("lat_ch", out_ch, 0);
    tick();
    chk("lat_gone", out_valid, 0);

    // Round-robin with 2 packets on each channel: expect 0,1,2,3,0,1,2,3 with no bubbles.
    do_reset();
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < NUM_CH; c++) set_wr(c, mk(c, n), 1);
      tick();
    end
    wr_en = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_valid", out_valid, 1);
      chk("rr_ch", out_ch, k % 4);
      tick();
    end
    chk("rr_empty", out_valid, 0);

    // Hold the output for 5 stalled cycles, then release it.
    do_reset();
    pkt_a = mk(3, 0);
    pkt_b = mk(3, 1);
    set_wr(3, pkt_a, 1);
    tick();
    set_wr(3, pkt_b, 1);
    tick();
    wr_en = '0;
    chk("hold_valid0", out_valid, 1);
    chk("hold_data0", out_data, pkt_a);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pkt_a);
      chk("hold_ch", out_ch, 3);
    end
    out_ready = 1'b1;
    tick();
    chk("hold_next_data", out_data, pkt_b);
    chk("hold_next_valid", out_valid, 1);
    tick();
    chk("hold_drained", out_valid, 0);

    // Fill ch2 while a ch0 packet blocks the slot: the flags must follow the table.
    do_reset();
    set_wr(0, mk(0, 0), 1);
    tick();
    wr_en = '0;
    tick();
    chk("fill_slot_busy", out_valid, 1);
    for (int i = 0; i < 17; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (tbl[i].wr_en[c]) set_wr(c, mk(c, i), tbl[i].keep);
      tick();
      wr_en = '0;
      chk("fill_af", almost_full, tbl[i].exp_af);
      chk("fill_full", full, tbl[i].exp_full);
      chk("fill_ovf", overflow, tbl[i].exp_ovf);
    end
    drain(64);
    chk("fill_ovf_sticky", overflow, 4'b0100);

    // Fill ch1, then write while ch1 is full on the same edge that pops ch1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_wr(1, mk(1, i), 1);
      tick();
    end
    wr_en = '0;
    chk("popfull_full", full, 4'b0010);
    set_wr(1, mk(1, 99), 0);
    out_ready = 1'b1;
    tick();
    wr_en = '0;
    chk("popfull_full_after", full, 0);
    chk("popfull_ovf", overflow, 4'b0010);
    chk("popfull_af", almost_full, 4'b0010);
    drain(64);

    // Reset in mid-operation: pending packets are discarded and never appear.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) set_wr(c, mk(c, i), 1);
      tick();
    end
    chk("midrst_busy", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = '0;
    for (int c = 0; c < NUM_CH; c++) sb[c[1:0]].delete();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_full", full, 0);
    chk("midrst_af", almost_full, 0);
    chk("midrst_ovf", overflow, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("midrst_stale", out_valid, 0);
    end

    for (int c = 0; c < NUM_CH; c++) chk("sb_empty", sb[c[1:0]].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
